processing_element_ws: RTL and testbench

Weight-stationary multiply-accumulate processing element: the cell replicated across a systolic array.
- Weights shift in vertically and are held stationary in each PE.
- Activations flow horizontally and partial sums flow vertically.
- Each PE adds stored weight × activation to the incoming partial sum and registers everything toward its neighbours.

---
 rtl/processing_element_ws.sv | 107 ++++++++++
 tb/tb_processing_element_ws.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/processing_element_ws.sv
// rtl/processing_element_ws.sv - weight-stationary MAC processing element for a systolic array
// Optional build macro: PS_SATURATE_EN (saturating compute-mode partial sum instead of wrap-around)
module processing_element_ws #(
  parameter int WORDWIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     enable_in,
  input  logic [WORDWIDTH-1:0]     w_in,
  input  logic [WORDWIDTH-1:0]     a_in,
  input  logic [4*WORDWIDTH-1:0]   ps_in,
  output logic                     enable_out,
  output logic [WORDWIDTH-1:0]     w_out,
  output logic [WORDWIDTH-1:0]     a_out,
  output logic [4*WORDWIDTH-1:0]   ps_out
);

  localparam int PW = 4 * WORDWIDTH;
  localparam int MW = 2 * WORDWIDTH;

  localparam logic MODE_LOAD    = 1'b0;
  localparam logic MODE_COMPUTE = 1'b1;

  logic [WORDWIDTH-1:0] weight_reg;

  // Operands are sign-extended to the full product width so the multiply
  // is a same-width operation and keeps two's complement semantics.
  logic signed [MW-1:0] weight_ext;
  logic signed [MW-1:0] act_ext;
  logic signed [MW-1:0] product;
  logic        [PW-1:0] product_ext;
  logic        [PW-1:0] sum_wrap;
  logic        [PW-1:0] sum_next;

  logic load_en;
  logic compute_en;

  assign load_en    = enable_in && (mode == MODE_LOAD);
  assign compute_en = enable_in && (mode == MODE_COMPUTE);

  // Signed product of the stationary weight and the incoming activation,
  // sign-extended to partial-sum width and added to the upstream sum.
  always_comb begin
    weight_ext  = {{WORDWIDTH{weight_reg[WORDWIDTH-1]}}, weight_reg};
    act_ext     = {{WORDWIDTH{a_in[WORDWIDTH-1]}}, a_in};
    product     = weight_ext * act_ext;
    product_ext = {{(PW-MW){product[MW-1]}}, product};
    sum_wrap    = ps_in + product_ext;
  end

`ifdef PS_SATURATE_EN
  logic pos_overflow;
  logic neg_overflow;

  // Overflow only happens when both addends share a sign and the result
  // flips it; clamp to the extreme representable partial sum.
  always_comb begin
    pos_overflow = !ps_in[PW-1] && !product_ext[PW-1] &&  sum_wrap[PW-1];
    neg_overflow =  ps_in[PW-1] &&  product_ext[PW-1] && !sum_wrap[PW-1];
    if (pos_overflow) begin
      sum_next = {1'b0, {(PW-1){1'b1}}};
    end else if (neg_overflow) begin
      sum_next = {1'b1, {(PW-1){1'b0}}};
    end else begin
      sum_next = sum_wrap;
    end
  end
`else
  // Plain modular accumulation; overflow wraps silently.
  always_comb begin
    sum_next = sum_wrap;
  end
`endif

  // One-cycle enable pipeline toward the downstream PE, independent of mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      enable_out <= 1'b0;
    end else begin
      enable_out <= enable_in;
    end
  end

  // Stationary weight: shifts in only during an enabled load cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_reg <= '0;
    end else if (load_en) begin
      weight_reg <= w_in;
    end
  end

  // Activation forwarding and partial-sum accumulation during enabled compute cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out  <= '0;
      ps_out <= '0;
    end else if (compute_en) begin
      a_out  <= a_in;
      ps_out <= sum_next;
    end
  end

  assign w_out = weight_reg;

endmodule

// File: tb/tb_processing_element_ws.sv
// tb/tb_processing_element_ws.sv - scoreboard testbench for processing_element_ws
module tb_processing_element_ws;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        enable_in;
  logic [7:0]  w_in;
  logic [7:0]  a_in;
  logic [31:0] ps_in;
  logic        enable_out;
  logic [7:0]  w_out;
  logic [7:0]  a_out;
  logic [31:0] ps_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  w;
    logic [7:0]  a;
    logic [31:0] ps;
    logic        en;
  } exp_t;

  exp_t sb[$];

  logic [7:0]  m_w  = '0;
  logic [7:0]  m_a  = '0;
  logic [31:0] m_ps = '0;
  logic        m_en = 1'b0;

  processing_element_ws #(.WORDWIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .enable_in  (enable_in),
    .w_in       (w_in),
    .a_in       (a_in),
    .ps_in      (ps_in),
    .enable_out (enable_out),
    .w_out      (w_out),
    .a_out      (a_out),
    .ps_out     (ps_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model_mac(input logic [31:0] ps, input logic [7:0] w, input logic [7:0] a);
    longint s;
    s = longint'($signed(ps)) + longint'($signed(w)) * longint'($signed(a));
`ifdef PS_SATURATE_EN
    if (s > 64'sd2147483647) s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  // Drive one cycle of inputs, advance the reference model, queue the expectation, then step past the edge.
  task automatic apply(input logic rst, input logic en, input logic md,
                       input logic [7:0] w, input logic [7:0] a, input logic [31:0] ps);
    exp_t e;
    reset = rst; enable_in = en; mode = md; w_in = w; a_in = a; ps_in = ps;
    if (rst) begin
      m_w = '0; m_a = '0; m_ps = '0; m_en = 1'b0;
    end else begin
      m_en = en;
      if (en && !md) m_w = w;
      if (en && md) begin
        m_ps = model_mac(ps, m_w, a);
        m_a  = a;
      end
    end
    e.w = m_w; e.a = m_a; e.ps = m_ps; e.en = m_en;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    apply(1'b1, 1'b1, 1'b1, 8'h5A, 8'hC3, 32'h1234_5678);
    e = sb.pop_front();
    checks++; if (w_out !== 8'd0)       begin errors++; $display("FAIL reset_w_out got %0h want 0", w_out); end
    checks++; if (a_out !== 8'd0)       begin errors++; $display("FAIL reset_a_out got %0h want 0", a_out); end
    checks++; if (ps_out !== 32'd0)     begin errors++; $display("FAIL reset_ps_out got %0h want 0", ps_out); end
    checks++; if (enable_out !== 1'b0)  begin errors++; $display("FAIL reset_enable_out got %0b want 0", enable_out); end
    checks++; if (ps_out !== e.ps)      begin errors++; $display("FAIL reset_sb_ps got %0h want %0h", ps_out, e.ps); end
  endtask

  task automatic test_weight_load();
    exp_t e;
    apply(1'b0, 1'b1, 1'b0, 8'd3, 8'd0, 32'd0);
    e = sb.pop_front();
    checks++; if (w_out !== 8'd3)       begin errors++; $display("FAIL load_w_out got %0d want 3", w_out); end
    checks++; if (a_out !== 8'd0)       begin errors++; $display("FAIL load_a_out got %0d want 0", a_out); end
    checks++; if (ps_out !== 32'd0)     begin errors++; $display("FAIL load_ps_out got %0d want 0", ps_out); end
    checks++; if (enable_out !== e.en)  begin errors++; $display("FAIL load_enable_out got %0b want %0b", enable_out, e.en); end
  endtask

  task automatic test_compute();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b1, 1'b1, 8'd0, 8'd2, 32'd5);
      e = sb.pop_front();
      checks++; if (ps_out !== 32'd11) begin errors++; $display("FAIL compute_ps[%0d] got %0d want 11", i, ps_out); end
      checks++; if (a_out !== 8'd2)    begin errors++; $display("FAIL compute_a[%0d] got %0d want 2", i, a_out); end
      checks++; if (w_out !== e.w)     begin errors++; $display("FAIL compute_w[%0d] got %0d want %0d", i, w_out, e.w); end
    end
  endtask

  task automatic test_signed();
    exp_t e;
    apply(1'b0, 1'b1, 1'b0, 8'hFC, 8'd0, 32'd0);
    void'(sb.pop_front());
    apply(1'b0, 1'b1, 1'b1, 8'd0, 8'd3, 32'd10);
    e = sb.pop_front();
    checks++; if (ps_out !== 32'hFFFF_FFFE) begin errors++; $display("FAIL signed_neg_w got %0h want fffffffe", ps_out); end
    checks++; if (ps_out !== e.ps)          begin errors++; $display("FAIL signed_neg_w_sb got %0h want %0h", ps_out, e.ps); end
    apply(1'b0, 1'b1, 1'b0, 8'h80, 8'd0, 32'd0);
    void'(sb.pop_front());
    apply(1'b0, 1'b1, 1'b1, 8'd0, 8'h80, 32'd0);
    e = sb.pop_front();
    checks++; if (ps_out !== 32'd16384) begin errors++; $display("FAIL signed_min_sq got %0d want 16384", ps_out); end
    checks++; if (a_out !== e.a)        begin errors++; $display("FAIL signed_min_a got %0h want %0h", a_out, e.a); end
  endtask

  task automatic test_enable_gating();
    exp_t e;
    logic [7:0]  w0, a0;
    logic [31:0] p0;
    w0 = w_out; a0 = a_out; p0 = ps_out;
    apply(1'b0, 1'b0, 1'b1, 8'd0, 8'd7, 32'd100);
    e = sb.pop_front();
    checks++; if (a_out !== a0)         begin errors++; $display("FAIL gate_a got %0h want %0h", a_out, a0); end
    checks++; if (ps_out !== p0)        begin errors++; $display("FAIL gate_ps got %0h want %0h", ps_out, p0); end
    checks++; if (w_out !== w0)         begin errors++; $display("FAIL gate_w got %0h want %0h", w_out, w0); end
    checks++; if (enable_out !== 1'b0)  begin errors++; $display("FAIL gate_enable_out got %0b want 0", enable_out); end
    apply(1'b0, 1'b0, 1'b0, 8'd9, 8'd0, 32'd0);
    e = sb.pop_front();
    checks++; if (w_out !== e.w)        begin errors++; $display("FAIL gate_load_w got %0h want %0h", w_out, e.w); end
    checks++; if (w_out === 8'd9)       begin errors++; $display("FAIL gate_load_took got %0h want not 9", w_out); end
  endtask

  task automatic test_mode_switch();
    exp_t e;
    apply(1'b0, 1'b1, 1'b0, 8'd5, 8'd0, 32'd0);
    void'(sb.pop_front());
    apply(1'b0, 1'b1, 1'b1, 8'd77, 8'd2, 32'd0);
    e = sb.pop_front();
    checks++; if (ps_out !== 32'd10) begin errors++; $display("FAIL switch_ps got %0d want 10", ps_out); end
    checks++; if (w_out !== 8'd5)    begin errors++; $display("FAIL switch_w got %0d want 5", w_out); end
    checks++; if (enable_out !== e.en) begin errors++; $display("FAIL switch_en got %0b want %0b", enable_out, e.en); end
  endtask

  task automatic test_overflow();
    exp_t e;
    apply(1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 32'd0);
    void'(sb.pop_front());
    apply(1'b0, 1'b1, 1'b1, 8'd0, 8'd1, 32'h7FFF_FFFF);
    e = sb.pop_front();
`ifdef PS_SATURATE_EN
    checks++; if (ps_out !== 32'h7FFF_FFFF) begin errors++; $display("FAIL ovf_pos got %0h want 7fffffff", ps_out); end
`else
    checks++; if (ps_out !== 32'h8000_0000) begin errors++; $display("FAIL ovf_pos got %0h want 80000000", ps_out); end
`endif
    apply(1'b0, 1'b1, 1'b1, 8'd0, 8'hFF, 32'h8000_0000);
    e = sb.pop_front();
    checks++; if (ps_out !== e.ps) begin errors++; $display("FAIL ovf_neg got %0h want %0h", ps_out, e.ps); end
    apply(1'b1, 1'b1, 1'b1, 8'd0, 8'd4, 32'd1000);
    e = sb.pop_front();
    checks++; if (ps_out !== 32'd0) begin errors++; $display("FAIL midrun_reset_ps got %0h want 0", ps_out); end
    checks++; if (w_out !== 8'd0)   begin errors++; $display("FAIL midrun_reset_w got %0h want 0", w_out); end
    checks++; if (a_out !== e.a)    begin errors++; $display("FAIL midrun_reset_a got %0h want %0h", a_out, e.a); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 40; i++) begin
      apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            8'($urandom), 8'($urandom), (i % 5 == 0) ? 32'h7FFF_FF00 : $urandom);
      e = sb.pop_front();
      checks++;
      if (ps_out !== e.ps || a_out !== e.a || w_out !== e.w || enable_out !== e.en) begin
        errors++;
        $display("FAIL b2b[%0d] got ps=%0h a=%0h w=%0h en=%0b want ps=%0h a=%0h w=%0h en=%0b",
                 i, ps_out, a_out, w_out, enable_out, e.ps, e.a, e.w, e.en);
      end
    end
  endtask

  initial begin
    reset = 1'b1; mode = 1'b0; enable_in = 1'b0; w_in = '0; a_in = '0; ps_in = '0;
    test_reset();
    test_weight_load();
    test_compute();
    test_signed();
    test_enable_gating();
    test_mode_switch();
    test_overflow();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
